// File: rtl/truth_table_prober_pkg.sv
// Shared types and constants for the truth-table prober.
//   prober_state_t        : controller states (IDLE, SETTLE, FINISH)
//   DEFAULT_SETTLE_CYCLES : default extra hold cycles per probe vector
//   CNT_W                 : width of the settle counter (settle range 0..255)
//   tt_width(n)           : truth-table width for an n-input device, 2**n
package truth_table_prober_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        FINISH = 2'd2
    } prober_state_t;

    localparam int DEFAULT_SETTLE_CYCLES = 4;
    localparam int CNT_W                 = 8;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/prober_settle_timer.sv
// Per-vector settle counter for the truth-table prober.
// Ports:
//   clk      in  : clock, rising edge
//   rst_n    in  : synchronous active-low reset, clears the count
//   clear    in  : restart the count at zero (wins over enable)
//   enable   in  : advance the count by one
//   limit    in  : count value at which the current vector is sampled
//   at_limit out : count equals limit
module prober_settle_timer
    import truth_table_prober_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             at_limit
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (enable) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign at_limit = (cnt_reg == limit);

endmodule

// File: rtl/truth_table_prober.sv
// Sequential characterizer for a small combinational device (DUC).
// Walks probe_in through all 2**N_IN vectors, holds each for
// SETTLE_CYCLES+1 cycles, samples probe_out on the last edge of each
// vector, assembles the truth table and compares it to the expected value
// captured when the run was accepted.
// Ports:
//   clk         in  : clock, rising edge
//   rst_n       in  : synchronous active-low reset (aborts a run, no done)
//   start       in  : request a run, accepted only while idle
//   expected    in  : expected truth table, captured on the accepted start
//   probe_in    out : vector driven to the DUC (MSB = in1)
//   probe_out   in  : DUC output, synchronous to clk
//   busy        out : high from accepted start through the final sample edge
//   done        out : one-cycle pulse, truth_table/match valid with it
//   truth_table out : bit i = probe_out sampled while probe_in == i
//   match       out : truth_table equals the captured expected value
module truth_table_prober
    import truth_table_prober_pkg::*;
#(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    localparam int TT_W         = tt_width(N_IN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [TT_W-1:0] expected,
    output logic [N_IN-1:0] probe_in,
    input  logic            probe_out,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] truth_table,
    output logic            match
);

    localparam logic [CNT_W-1:0] SETTLE_LIMIT = CNT_W'(SETTLE_CYCLES);
    localparam logic [N_IN-1:0]  IDX_LAST     = N_IN'(TT_W - 1);
    localparam logic [N_IN-1:0]  IDX_ONE      = N_IN'(1);

    prober_state_t   state_reg;
    logic [N_IN-1:0] idx_reg;
    logic [TT_W-1:0] tt_reg;
    logic [TT_W-1:0] exp_reg;
    logic [TT_W-1:0] tt_assembled;
    logic            at_limit;
    logic            timer_clear;
    logic            timer_enable;

    // The counter restarts when a run is accepted and on every sample edge,
    // so each vector sees exactly SETTLE_CYCLES+1 edges.
    assign timer_enable = (state_reg == SETTLE);
    assign timer_clear  = ((state_reg == IDLE) && start) ||
                          ((state_reg == SETTLE) && at_limit);

    prober_settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (timer_clear),
        .enable   (timer_enable),
        .limit    (SETTLE_LIMIT),
        .at_limit (at_limit)
    );

    // Collected bits with the live probe_out merged into the current slot,
    // so the final result can include the bit sampled on the last edge.
    generate
        for (genvar gi = 0; gi < TT_W; gi++) begin : g_assemble
            assign tt_assembled[gi] = (idx_reg == N_IN'(gi)) ? probe_out : tt_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            tt_reg      <= '0;
            exp_reg     <= '0;
            probe_in    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= '0;
            match       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        exp_reg   <= expected;
                        idx_reg   <= '0;
                        tt_reg    <= '0;
                        probe_in  <= '0;
                        busy      <= 1'b1;
                        state_reg <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (at_limit) begin
                        tt_reg <= tt_assembled;
                        if (idx_reg != IDX_LAST) begin
                            idx_reg  <= idx_reg + IDX_ONE;
                            probe_in <= idx_reg + IDX_ONE;
                        end else begin
                            truth_table <= tt_assembled;
                            match       <= (tt_assembled == exp_reg);
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            probe_in    <= '0;
                            state_reg   <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    // Single cover cycle for the done pulse; start is not
                    // looked at here.
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/truth_table_prober.md
Name: truth_table_prober

Overview:
- Sequential characterizer for the single-output 3-input logic modules the compiler emits (e.g. a module whose truth table is 0x42).
- Writer side: a module implements a truth table. This block is the reader: it drives all 2^N_IN input vectors into a device under characterization (DUC), waits a settle interval, and samples its output.
- It assembles the sampled bits into the hex truth-table ID and compares that ID against an expected value.
- Used in self-check harnesses and on-chip BIST around compiled gate netlists.

Parameters:
- N_IN, 3, number of DUC inputs; TT_W = 2**N_IN is the truth-table width (8 at default).
- SETTLE_CYCLES, 4, extra cycles each vector is held before sampling; range 0..255.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request a probe run; honoured only when busy=0.
- expected  input  TT_W  expected truth table; captured on the accepted start.
- probe_in  output  N_IN  vector driven to the DUC; MSB = in1, LSB = in(N_IN).
- probe_out  input  1  DUC output being characterized.
- busy  output  1  high from the accepted start through the final sample edge.
- done  output  1  one-cycle pulse; truth_table and match are valid in the same cycle.
- truth_table  output  TT_W  bit i = probe_out sampled while probe_in == i.
- match  output  1  truth_table == captured expected.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - probe_in, truth_table, match, done, busy and the internal idx, cnt and shift register all go to 0.
  - This applies mid-run too. The partial result is discarded and no done is issued.
- States: IDLE, SETTLE, FINISH.
- IDLE, start=1 at edge E0:
  - Capture expected into exp_q; set idx=0, probe_in=0, cnt=0, busy=1.
  - Go to SETTLE.
- SETTLE:
  - Each vector is held for SETTLE_CYCLES+1 cycles.
  - At the edge where cnt == SETTLE_CYCLES, sample probe_out into tt_q[idx]. That is the last edge of the vector, so probe_out is seen after full settle.
  - If idx < TT_W-1 at that edge: idx++, probe_in=idx+1, cnt=0.
  - Otherwise, at that edge: truth_table <= the assembled value (including the bit just sampled), match <= (assembled == exp_q), done <= 1, busy <= 0, probe_in <= 0. Go to FINISH.
  - At other edges: cnt++.
- FINISH: lasts one cycle; done returns to 0 and the state returns to IDLE. start is ignored in FINISH.
- Latency:
  - The last sample edge is E0 + TT_W*(SETTLE_CYCLES+1).
  - done is high in the cycle after that edge: 40 cycles after E0 at the defaults.
- start while busy, or while in FINISH: ignored. expected changes after E0 have no effect.
- truth_table and match hold their values until the next done or reset; a new start does not clear them.
- SETTLE_CYCLES=0: the vector changes every cycle and each bit is sampled on the cycle's only edge.
- probe_out is treated as synchronous to clk. Any synchronizer belongs to the integrator, not this block.
- cnt is 8 bits and idx is N_IN bits; no wrap can occur inside a run.

Decomposition:
- Package truth_table_prober_pkg holds:
  - the state enum (IDLE, SETTLE, FINISH);
  - the localparam function tt_width(n) = 2**n;
  - the default-settle constant.
- One natural sub-module, prober_settle_timer: an 8-bit counter with clear and an at_limit flag. It is compared against SETTLE_CYCLES and cleared per vector.
- The FSM, the index register and the truth-table assembly remain in the top module.

Test Plan:
- DUC = rule 0x42 model (out=1 only for 001 and 110), defaults, expected=8'h42, start at E0:
  - probe_in steps 0..7, each held 5 cycles;
  - done pulses one cycle, 40 cycles after E0;
  - truth_table=8'h42, match=1.
- Same DUC, expected=8'h24: truth_table=8'h42, match=0, done still pulses.
- SETTLE_CYCLES=0, DUC = 3-input AND, expected=8'h80: done 8 cycles after start, truth_table=8'h80, match=1.
- start pulsed again at cycles 5 and 20 of a run:
  - ignored; exactly one done;
  - probe_in sequence unchanged;
  - expected changed mid-run does not affect match.
- rst_n=0 for one edge at cycle 17 of a run:
  - next cycle busy=0, probe_in=0, truth_table=0, no done;
  - a following start completes normally with 8'h42.
- DUC output delayed by 3 cycles relative to probe_in:
  - SETTLE_CYCLES=4 gives the correct 8'h42;
  - SETTLE_CYCLES=1 gives a shifted/incorrect table with match=0, which demonstrates that the settle behaviour is effective.
